// File: rtl/mms_ptw_if.sv
// Bundle between the Sv32 instruction-side page-table walker, its ITLB requester and the PTE read port.
// slave = walker side, master = ITLB/memory side.
interface mms_ptw_if #(
    parameter int PPN1_WD = 12,
    parameter int PPN0_WD = 10,
    parameter int VPN1_WD = 10,
    parameter int VPN0_WD = 10,
    parameter int ASID_WD = 9,
    parameter int PA_WD   = PPN1_WD + PPN0_WD + 12
);
    logic                       req_valid;
    logic                       req_ready;
    logic [VPN1_WD+VPN0_WD-1:0] req_vpn;
    logic [ASID_WD-1:0]         req_asid;
    logic                       satp_mode;
    logic [PPN1_WD+PPN0_WD-1:0] satp_ppn;
    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [PA_WD-1:0]           mem_req_addr;
    logic                       mem_resp_valid;
    logic [31:0]                mem_resp_pte;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [31:0]                resp_pte;
    logic [VPN1_WD+VPN0_WD-1:0] resp_vpn;
    logic [ASID_WD-1:0]         resp_asid;
    logic                       resp_super;
    logic                       resp_fault;
    logic                       flush;

    modport slave (
        input  req_valid, req_vpn, req_asid, satp_mode, satp_ppn,
        input  mem_req_ready, mem_resp_valid, mem_resp_pte, resp_ready, flush,
        output req_ready, mem_req_valid, mem_req_addr,
        output resp_valid, resp_pte, resp_vpn, resp_asid, resp_super, resp_fault
    );

    modport master (
        output req_valid, req_vpn, req_asid, satp_mode, satp_ppn,
        output mem_req_ready, mem_resp_valid, mem_resp_pte, resp_ready, flush,
        input  req_ready, mem_req_valid, mem_req_addr,
        input  resp_valid, resp_pte, resp_vpn, resp_asid, resp_super, resp_fault
    );
endinterface

// File: rtl/mms_ptw.sv
// Sv32 two-level page-table walker for ITLB misses: one walk in flight, no A/D update,
// flush aborts any walk and drains an outstanding PTE read if one was issued.
//
// state   | meaning
// IDLE    | waiting for a walk request (only accepted with satp_mode=1)
// L1_REQ  | issuing read of the level-1 PTE at {root ppn, vpn1, 00}
// L1_WAIT | level-1 read accepted, waiting for the PTE
// L0_REQ  | issuing read of the level-0 PTE at {L1 pte.ppn, vpn0, 00}
// L0_WAIT | level-0 read accepted, waiting for the PTE
// DONE    | presenting the result until resp_ready (or flush)
// DRAIN   | walk aborted with a read outstanding; discard its response
module mms_ptw #(
    parameter int PPN1_WD = 12,
    parameter int PPN0_WD = 10,
    parameter int VPN1_WD = 10,
    parameter int VPN0_WD = 10,
    parameter int ASID_WD = 9,
    parameter int PA_WD   = 34
) (
    input logic      clk,
    input logic      rst,
    mms_ptw_if.slave bus
);
    localparam int PPN_WD = PPN1_WD + PPN0_WD;
    localparam int VPN_WD = VPN1_WD + VPN0_WD;

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [VPN_WD-1:0]   vpn_q, vpn_d;
    logic [ASID_WD-1:0]  asid_q, asid_d;
    logic [PPN_WD-1:0]   root_q, root_d;
    logic [PPN_WD-1:0]   next_ppn_q, next_ppn_d;
    logic [31:0]         rpte_q, rpte_d;
    logic                super_q, super_d;
    logic                fault_q, fault_d;

    logic [31:0]         pte;
    logic                pte_invalid, pte_leaf, pte_acc, ppn0_nz;
    logic                l1_fault, l0_fault;
    logic                req_ready_w;
    logic [PA_WD-1:0]    addr_l1, addr_l0;

    // Sv32 PTE: ppn[31:10], D7 A6 G5 U4 X3 W2 R1 V0
    assign pte         = bus.mem_resp_pte;
    assign pte_invalid = !pte[0] || (!pte[1] && pte[2]);
    assign pte_leaf    = pte[1] || pte[3];
    assign pte_acc     = pte[6];
    assign ppn0_nz     = (pte[10 +: PPN0_WD] != '0);
    assign l1_fault    = pte_invalid || ppn0_nz || !pte_acc;
    assign l0_fault    = pte_invalid || !pte_leaf || !pte_acc;

    assign req_ready_w = !rst && (state_q == IDLE) && bus.satp_mode && !bus.flush;
    assign addr_l1     = {root_q, vpn_q[VPN_WD-1 -: VPN1_WD], 2'b00};
    assign addr_l0     = {next_ppn_q, vpn_q[VPN0_WD-1:0], 2'b00};

    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        asid_d     = asid_q;
        root_d     = root_q;
        next_ppn_d = next_ppn_q;
        rpte_d     = rpte_q;
        super_d    = super_q;
        fault_d    = fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_w) begin
                    state_d = L1_REQ;
                    vpn_d   = bus.req_vpn;
                    asid_d  = bus.req_asid;
                    root_d  = bus.satp_ppn;
                end
            end
            L1_REQ, L0_REQ: begin
                if (bus.flush) begin
                    state_d = bus.mem_req_ready ? DRAIN : IDLE;
                end else if (bus.mem_req_ready) begin
                    state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end
            L1_WAIT: begin
                if (bus.flush) begin
                    state_d = bus.mem_resp_valid ? IDLE : DRAIN;
                end else if (bus.mem_resp_valid) begin
                    if (!pte_invalid && !pte_leaf) begin
                        state_d    = L0_REQ;
                        next_ppn_d = pte[10 +: PPN_WD];
                    end else begin
                        state_d = DONE;
                        rpte_d  = pte;
                        fault_d = l1_fault;
                        super_d = !l1_fault;
                    end
                end
            end
            L0_WAIT: begin
                if (bus.flush) begin
                    state_d = bus.mem_resp_valid ? IDLE : DRAIN;
                end else if (bus.mem_resp_valid) begin
                    state_d = DONE;
                    rpte_d  = pte;
                    fault_d = l0_fault;
                    super_d = 1'b0;
                end
            end
            DONE: begin
                if (bus.flush || bus.resp_ready) state_d = IDLE;
            end
            DRAIN: begin
                if (bus.mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vpn_q      <= '0;
            asid_q     <= '0;
            root_q     <= '0;
            next_ppn_q <= '0;
            rpte_q     <= '0;
            super_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            asid_q     <= asid_d;
            root_q     <= root_d;
            next_ppn_q <= next_ppn_d;
            rpte_q     <= rpte_d;
            super_q    <= super_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.req_ready     = req_ready_w;
    assign bus.mem_req_valid = !rst && ((state_q == L1_REQ) || (state_q == L0_REQ));
    assign bus.mem_req_addr  = (state_q == L1_REQ) ? addr_l1 :
                               (state_q == L0_REQ) ? addr_l0 : '0;
    assign bus.resp_valid    = !rst && (state_q == DONE);
    assign bus.resp_pte      = rpte_q;
    assign bus.resp_vpn      = vpn_q;
    assign bus.resp_asid     = asid_q;
    assign bus.resp_super    = super_q;
    assign bus.resp_fault    = fault_q;
endmodule

// File: doc/mms_ptw.md
MMS_PTW -- requirements
Module: mms_ptw

Interface
REQ-001 SHALL expose parameter PA_WD, default 34, physical address width: PPN1_WD + PPN0_WD + 12.
REQ-002 SHALL expose port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL expose port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL expose req_valid in 1, req_ready out 1, req_vpn in VPN1_WD+VPN0_WD (vpn_t), req_asid in ASID_WD: ITLB-miss walk request.
REQ-005 SHALL expose satp_mode in 1 (1 = Sv32) and satp_ppn in PPN1_WD+PPN0_WD (ppn_t): root page-table PPN, sampled at request accept.
REQ-006 SHALL expose mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out PA_WD: PTE read request.
REQ-007 SHALL expose mem_resp_valid in 1, mem_resp_pte in 32 (pte_t): PTE read data; no back-pressure.
REQ-008 SHALL expose resp_valid out 1, resp_ready in 1, resp_pte out 32 (pte_t), resp_vpn out VPN width, resp_asid out ASID_WD, resp_super out 1 (megapage leaf), resp_fault out 1: walk result to ITLB refill.
REQ-009 SHALL expose flush in 1: abort any walk (sfence.vma / satp write).

Function
REQ-010 SHALL implement FSM states IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, DRAIN; one walk in flight at a time.
REQ-011 req_ready SHALL be 1 only in IDLE with satp_mode=1 and flush=0; request accepted on req_valid&req_ready; vpn, asid, satp_ppn latched; IDLE->L1_REQ.
REQ-012 In L1_REQ: mem_req_valid=1, mem_req_addr={satp_ppn, vpn1, 2'b00}; on mem_req_ready -> L1_WAIT.
REQ-013 In L0_REQ: mem_req_valid=1, mem_req_addr={L1 pte.ppn, vpn0, 2'b00}; on mem_req_ready -> L0_WAIT.
REQ-014 mem_req_valid/mem_req_addr SHALL remain stable until handshake, except when aborted by flush.
REQ-015 PTE classification at mem_resp_valid: invalid if V=0 or (R=0 and W=1); leaf if R=1 or X=1; else pointer.
REQ-016 L1_WAIT: invalid -> DONE fault=1; pointer -> L0_REQ; leaf with ppn0!=0 (misaligned megapage) -> DONE fault=1; leaf with A=0 -> DONE fault=1; else DONE fault=0, super=1.
REQ-017 L0_WAIT: invalid, pointer (level exhausted) or A=0 -> DONE fault=1; else DONE fault=0, super=0.
REQ-018 No hardware A/D update; D bit passed through unchanged.
REQ-019 DONE: resp_valid=1 with resp_pte = final fetched PTE (faulting PTE on fault), latched vpn/asid; outputs stable until resp_ready; on resp_valid&resp_ready -> IDLE.
REQ-020 Latency (zero-wait memory, resp_ready=1): accept at cycle 0; mem_req_valid cycle 1; response of 2-level walk with mem_resp 1 cycle after each handshake gives resp_valid at cycle 5; megapage at cycle 3.
REQ-021 flush in L1_REQ/L0_REQ (handshake not completed that cycle) -> IDLE; mem_req_valid drops next cycle.
REQ-022 flush in L1_REQ/L0_REQ coincident with mem_req_ready, or in L1_WAIT/L0_WAIT without mem_resp_valid -> DRAIN; DRAIN waits for mem_resp_valid, discards it, -> IDLE.
REQ-023 flush in WAIT state coincident with mem_resp_valid -> IDLE, response discarded.
REQ-024 flush in DONE -> IDLE, resp_valid drops, no handshake required.
REQ-025 No resp_valid SHALL be produced for any aborted walk; flush has priority over every other transition.
REQ-026 satp_mode/satp_ppn changes mid-walk SHALL NOT affect the walk (latched values used).

Reset
REQ-027 rst=1 at a clock edge -> IDLE; mem_req_valid=0, resp_valid=0, req_ready=0 while rst=1, resp_pte/resp_vpn/resp_asid/resp_super/resp_fault=0.
REQ-028 Reset mid-walk abandons walk; a late mem_resp_valid arriving in IDLE SHALL be ignored.

Verification
REQ-029 satp_ppn=0x00010, vpn=0x004_005; L1 PTE ppn=0x00020 V=1 RWX=0; L0 PTE V=1 R=1 X=1 A=1 -> addrs 0x0_0001_0010 then 0x0_0002_0014; resp fault=0 super=0.
REQ-030 L1 PTE V=1 R=1 A=1 ppn0=0 -> single mem read, resp super=1 fault=0 at cycle 3; same with ppn0=0x001 -> fault=1.
REQ-031 L1 PTE V=0 -> fault=1, no second read; L0 PTE pointer (R=W=X=0, V=1) -> fault=1; L0 leaf A=0 -> fault=1.
REQ-032 flush asserted in L1_WAIT, mem_resp 3 cycles later -> no resp_valid, req_ready returns 1 after discard; next walk completes normally.
REQ-033 resp_ready=0 for 4 cycles in DONE -> resp outputs stable, req_ready=0; satp_mode=0 -> req_ready=0, no mem_req.
REQ-034 mem_req_ready=0 for 5 cycles -> mem_req_addr stable; rst pulse mid-walk -> all outputs per REQ-027 next cycle.
